// File: rtl/mult_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter_if
// Purpose  : Requester / response handshake bundle for mult_share_arbiter.
//            slave  = arbiter side, master = issue/writeback side.
// Revision : 1.0
// ============================================================================
interface mult_share_arbiter_if #(
  parameter int W0 = 8,
  parameter int W1 = 8
);
  logic               io_req0_valid;
  logic               io_req0_ready;
  logic [W0-1:0]      io_req0_bits_a;
  logic [W1-1:0]      io_req0_bits_b;
  logic               io_req1_valid;
  logic               io_req1_ready;
  logic [W0-1:0]      io_req1_bits_a;
  logic [W1-1:0]      io_req1_bits_b;
  logic               io_resp_valid;
  logic               io_resp_ready;
  logic [W0+W1-1:0]   io_resp_bits_prod;
  logic               io_resp_bits_id;
  logic               io_busy;

  modport slave (
    input  io_req0_valid, io_req0_bits_a, io_req0_bits_b,
    input  io_req1_valid, io_req1_bits_a, io_req1_bits_b,
    input  io_resp_ready,
    output io_req0_ready, io_req1_ready,
    output io_resp_valid, io_resp_bits_prod, io_resp_bits_id, io_busy
  );

  modport master (
    output io_req0_valid, io_req0_bits_a, io_req0_bits_b,
    output io_req1_valid, io_req1_bits_a, io_req1_bits_b,
    output io_resp_ready,
    input  io_req0_ready, io_req1_ready,
    input  io_resp_valid, io_resp_bits_prod, io_resp_bits_id, io_busy
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : PartialProductMultiplier
// Purpose  : Carry-save multiplier. Returns product as a redundant pair
//            (out0 + out1 == a*b modulo 2^(W0+W1+2)); tc selects signed mode.
// Revision : 1.0
// ============================================================================
module PartialProductMultiplier #(
  parameter int W0 = 8,
  parameter int W1 = 8
) (
  input  logic [W0-1:0]      a,
  input  logic [W1-1:0]      b,
  input  logic               tc,
  output logic [W0+W1+1:0]   out0,
  output logic [W0+W1+1:0]   out1
);
  localparam int PW = W0 + W1 + 2;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] sum;
  logic [PW-1:0] carry;
  logic [PW-1:0] pp;
  logic [PW-1:0] nsum;

  // Extend operands to full width, then fold every partial product into a
  // 3:2 carry-save accumulator; modular arithmetic keeps the signed result exact.
  always_comb begin
    a_ext = {{(PW-W0){tc & a[W0-1]}}, a};
    b_ext = {{(PW-W1){tc & b[W1-1]}}, b};
    sum   = '0;
    carry = '0;
    pp    = '0;
    nsum  = '0;
    for (int i = 0; i < PW; i++) begin
      pp    = b_ext[i] ? (a_ext << i) : '0;
      nsum  = sum ^ carry ^ pp;
      carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
      sum   = nsum;
    end
    out0 = sum;
    out1 = carry;
  end
endmodule

// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin share of one carry-save multiplier between two
//            requesters; two-stage pipeline with full back-pressure.
// Revision : 1.0
// ============================================================================
module mult_share_arbiter #(
  parameter int W0 = 8,
  parameter int W1 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_arbiter_if.slave  io
);
  localparam int PW = W0 + W1 + 2;

  logic          v1, v2, last, id1, id2;
  logic [W0-1:0] a1;
  logic [W1-1:0] b1;
  logic [PW-1:0] p0, p1, mo0, mo1;
  logic          s1_ready, s2_ready, grant0, grant1, grant_any;

  PartialProductMultiplier #(.W0(W0), .W1(W1)) u_mult (
    .a    (a1),
    .b    (b1),
    .tc   (1'b1),
    .out0 (mo0),
    .out1 (mo1)
  );

  // Ready chain: each stage may load when it is empty or its successor drains.
  assign s2_ready = !v2 | io.io_resp_ready;
  assign s1_ready = !v1 | s2_ready;

  // Round-robin: on contention the requester that did not win last time goes.
  assign grant0    = io.io_req0_valid & (!io.io_req1_valid | last);
  assign grant1    = io.io_req1_valid & (!io.io_req0_valid | !last);
  assign grant_any = grant0 | grant1;

  // Handshake outputs are forced idle while reset is asserted.
  assign io.io_req0_ready     = s1_ready & grant0 & !reset;
  assign io.io_req1_ready     = s1_ready & grant1 & !reset;
  assign io.io_resp_valid     = v2 & !reset;
  assign io.io_resp_bits_prod = (W0+W1)'(p0 + p1);
  assign io.io_resp_bits_id   = id2;
  assign io.io_busy           = (v1 | v2) & !reset;

  // Pipeline stages and arbitration pointer; data registers need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      last <= 1'b1;
    end else begin
      if (s2_ready) begin
        v2  <= v1;
        p0  <= mo0;
        p1  <= mo1;
        id2 <= id1;
      end
      if (s1_ready) begin
        v1  <= grant_any;
        a1  <= grant1 ? io.io_req1_bits_a : io.io_req0_bits_a;
        b1  <= grant1 ? io.io_req1_bits_b : io.io_req0_bits_b;
        id1 <= grant1;
        if (grant_any) begin
          last <= grant1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Purpose  : Self-checking bench for mult_share_arbiter (W0=W1=8) with an
//            in-order scoreboard of expected {id, product}.
// Revision : 1.0
// ============================================================================
module tb_mult_share_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];

  mult_share_arbiter_if #(.W0(8), .W1(8)) io ();

  mult_share_arbiter #(.W0(8), .W1(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare delivered responses in order, then record accepted pairs.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (io.io_resp_valid && io.io_resp_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_prod", 32'(io.io_resp_bits_prod), 32'(e.prod));
          chk("resp_id", 32'(io.io_resp_bits_id), 32'(e.id));
        end
      end
      if (io.io_req0_valid && io.io_req0_ready)
        sb.push_back('{id: 1'b0, prod: model(io.io_req0_bits_a, io.io_req0_bits_b)});
      if (io.io_req1_valid && io.io_req1_ready)
        sb.push_back('{id: 1'b1, prod: model(io.io_req1_bits_a, io.io_req1_bits_b)});
    end
  end

  // One isolated request on an empty pipe; result expected two edges later.
  task automatic single(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_prod);
    @(posedge clk); #1;
    io.io_resp_ready  = 1'b1;
    io.io_req0_valid  = !id;
    io.io_req1_valid  = id;
    io.io_req0_bits_a = a;
    io.io_req0_bits_b = b;
    io.io_req1_bits_a = a;
    io.io_req1_bits_b = b;
    @(negedge clk);
    chk("single_ready", 32'(id ? io.io_req1_ready : io.io_req0_ready), 32'd1);
    @(posedge clk); #1;
    io.io_req0_valid = 1'b0;
    io.io_req1_valid = 1'b0;
    @(negedge clk);
    chk("single_lat1_valid", 32'(io.io_resp_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(io.io_resp_valid), 32'd1);
    chk("single_prod", 32'(io.io_resp_bits_prod), 32'(exp_prod));
    chk("single_id", 32'(io.io_resp_bits_id), 32'(id));
  endtask

  initial begin
    int          acc;
    logic [15:0] held;

    reset             = 1'b1;
    io.io_req0_valid  = 1'b0;
    io.io_req1_valid  = 1'b0;
    io.io_req0_bits_a = '0;
    io.io_req0_bits_b = '0;
    io.io_req1_bits_a = '0;
    io.io_req1_bits_b = '0;
    io.io_resp_ready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(io.io_resp_valid), 32'd0);
    chk("rst_busy", 32'(io.io_busy), 32'd0);
    chk("rst_readies", 32'({io.io_req1_ready, io.io_req0_ready}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed products
    single(1'b0, 8'd3,    8'hFB, 16'hFFF1);
    single(1'b1, 8'h80,   8'h80, 16'h4000);
    single(1'b1, 8'h7F,   8'h80, 16'hC080);

    // Contention: both valid for 6 cycles, grants must alternate starting at 0
    @(posedge clk); #1;
    io.io_req0_valid = 1'b1;
    io.io_req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      io.io_req0_bits_a = 8'($urandom);
      io.io_req0_bits_b = 8'($urandom);
      io.io_req1_bits_a = 8'($urandom);
      io.io_req1_bits_b = 8'($urandom);
      @(negedge clk);
      chk("rr_grant", 32'({io.io_req1_ready, io.io_req0_ready}), (i % 2 == 1) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
    end
    io.io_req0_valid = 1'b0;
    io.io_req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: continuous stream while the consumer stalls 4 cycles
    @(posedge clk); #1;
    io.io_resp_ready = 1'b0;
    io.io_req0_valid = 1'b1;
    acc  = 0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      io.io_req0_bits_a = 8'(i * 7 + 1);
      io.io_req0_bits_b = 8'(8'hF0 + i);
      @(negedge clk);
      if (io.io_req0_ready) acc++;
      if (i == 2) held = io.io_resp_bits_prod;
      @(posedge clk); #1;
    end
    chk("stall_accepts", 32'(acc), 32'd2);
    chk("stall_readies", 32'({io.io_req1_ready, io.io_req0_ready}), 32'd0);
    chk("stall_valid", 32'(io.io_resp_valid), 32'd1);
    chk("stall_hold", 32'(io.io_resp_bits_prod), 32'(held));
    io.io_req0_valid = 1'b0;
    io.io_resp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall_drained", 32'(sb.size()), 32'd0);

    // Reset with both stages full drops in-flight work
    @(posedge clk); #1;
    io.io_resp_ready = 1'b0;
    io.io_req0_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("full_busy", 32'(io.io_busy), 32'd1);
    io.io_req1_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("inrst_readies", 32'({io.io_req1_ready, io.io_req0_ready}), 32'd0);
    chk("inrst_resp_valid", 32'(io.io_resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    io.io_resp_ready = 1'b1;
    @(negedge clk);
    chk("postrst_resp_valid", 32'(io.io_resp_valid), 32'd0);
    chk("postrst_busy", 32'(io.io_busy), 32'd0);
    chk("postrst_tie", 32'({io.io_req1_ready, io.io_req0_ready}), 32'd1);
    @(posedge clk); #1;
    io.io_req0_valid = 1'b0;
    io.io_req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("postrst_drained", 32'(sb.size()), 32'd0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      io.io_req0_valid  = 1'($urandom_range(0, 1));
      io.io_req1_valid  = 1'($urandom_range(0, 1));
      io.io_req0_bits_a = 8'($urandom);
      io.io_req0_bits_b = 8'($urandom);
      io.io_req1_bits_a = 8'($urandom);
      io.io_req1_bits_b = 8'($urandom);
      io.io_resp_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    io.io_req0_valid = 1'b0;
    io.io_req1_valid = 1'b0;
    io.io_resp_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    chk("rand_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk("final_busy", 32'(io.io_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
